axi_timer_irq_ctrl: RTL and testbench
=====================================

Name: axi_timer_irq_ctrl

Overview:
- Downstream companion of the AXI timer/counter top. Consumes its two done outputs (o_cnt0_done, o_cnt1_done).
- Converts done rising edges into sticky, maskable interrupt-pending bits and counts events per channel.
- Drives one combined level interrupt line to the CPU.
- Has its own AXI4-Lite slave port, using the same signal set as the timer block.

Parameters:
- AXI_ADDR_BW_p, 12, AXI address width (4 KiB window).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_axi_awaddr  in  AXI_ADDR_BW_p  write address
- i_axi_awvalid  in  1  write address valid
- i_axi_wdata  in  32  write data
- i_axi_wvalid  in  1  write data valid
- i_axi_bready  in  1  write response ready
- i_axi_araddr  in  AXI_ADDR_BW_p  read address
- i_axi_arvalid  in  1  read address valid
- i_axi_rready  in  1  read data ready
- o_axi_awready  out  1  write address ready
- o_axi_wready  out  1  write data ready
- o_axi_bresp  out  2  write response
- o_axi_bvalid  out  1  write response valid
- o_axi_arready  out  1  read address ready
- o_axi_rdata  out  32  read data
- o_axi_rresp  out  2  read response
- o_axi_rvalid  out  1  read data valid
- i_cnt0_done  in  1  done from timer/counter 0
- i_cnt1_done  in  1  done from timer/counter 1
- o_irq  out  1  combined interrupt, active high, registered

Behaviour:
- Reset:
  - Synchronous, active-low on rst_n, single clock clk.
  - All AXI outputs 0, o_irq 0.
  - PEND, EN, EVCNT0, EVCNT1 = 0. Edge-detect history regs = 0.
- Register map (decode addr[AXI_ADDR_BW_p-1:2]; addr[1:0] ignored):
  - 0x00 PEND[1:0]: read pending bits; write-1-to-clear.
  - 0x04 EN[1:0]: read/write interrupt enable.
  - 0x08 EVCNT0[31:0]: read/write; a write loads the written value.
  - 0x0C EVCNT1[31:0]: read/write; a write loads the written value.
  - 0x10 RAW[1:0]: read-only, current {i_cnt1_done, i_cnt0_done}. Writes are ignored with OKAY response.
  - Unused read bits return 0. Any other offset is unmapped.
- Edge detect:
  - edge_n = i_cntN_done & ~prev_n; prev_n is registered every cycle.
  - A done held high through reset release counts as one edge on the first cycle after reset.
  - A level held high produces exactly one edge.
- Edge seen at clock N:
  - PEND[n] = 1 and EVCNTn += 1 (32-bit, wraps 0xFFFFFFFF -> 0), both visible at N+1.
  - o_irq = |(PEND & EN) registered, so asserts at N+2.
- Simultaneous events:
  - W1C on PEND[n] in the same cycle as edge_n: set wins, bit stays 1.
  - Write to EVCNTn in the same cycle as edge_n: write value loaded, that increment dropped.
  - Clearing EN deasserts o_irq one cycle after the write commits; PEND is unchanged.
- AXI write channel:
  - awready and wready pulse high together for one cycle when awvalid & wvalid & ~bvalid. No lone AW or W acceptance.
  - Register updates on the accept cycle.
  - bvalid rises the next cycle and holds until bready.
  - bresp = 2'b00 OKAY for mapped offsets, 2'b10 SLVERR for unmapped (no state change).
  - Exactly one write outstanding.
- AXI read channel:
  - arready pulses one cycle when arvalid & ~rvalid.
  - rdata/rresp are registered on accept; rvalid rises the next cycle and holds with stable data until rready.
  - Unmapped offset: rdata 0, rresp SLVERR.
  - Reads have no side effects.
- Read and write channels are independent and may complete in the same cycle.
- Reset asserted mid-transaction: all state returns to reset values on that edge, in-flight responses are dropped, and bvalid/rvalid go low.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08, 0x0C, 0x10 -> all 0, rresp OKAY; o_irq 0.
- Write EN=0x3. Pulse i_cnt0_done one cycle at cycle N -> PEND=0x1 at N+1, o_irq=1 at N+2, EVCNT0=1. Write 0x1 to 0x00 -> PEND=0, o_irq=0 one cycle after the write commits.
- Hold i_cnt1_done high 10 cycles with EN=0x0 -> PEND=0x2, EVCNT1=1, o_irq stays 0. Write EN=0x2 -> o_irq=1.
- Same-cycle W1C of PEND[0] and i_cnt0_done edge -> PEND[0]=1. Write EVCNT0=0xFFFFFFFF, then one edge -> EVCNT0=0x00000000.
- Write and read to 0x20 -> bresp SLVERR; rdata 0 with rresp SLVERR; no register changes.
- Hold bready/rready low 5 cycles -> bvalid/rvalid and rdata stay stable; no second awready/arready until the handshake completes. Assert rst_n=0 mid-wait -> bvalid/rvalid 0 on the next edge.

Source files
------------

// File: rtl/axi_timer_irq_ctrl.sv
// -----------------------------------------------------------------------------
// axi_timer_irq_ctrl
//
// Interrupt controller that sits downstream of the AXI timer/counter block.
// It watches the two "done" outputs of the timer, turns each rising edge into
// a sticky pending bit, counts the events per channel and drives one combined
// level interrupt towards the CPU. Software reaches it over AXI4-Lite.
//
// Register map (word decode on addr[AXI_ADDR_BW_p-1:2], addr[1:0] ignored):
//   0x00 PEND[1:0]    read pending bits, write-1-to-clear
//   0x04 EN[1:0]      interrupt enable, read/write
//   0x08 EVCNT0[31:0] channel 0 event counter, read/write (write loads)
//   0x0C EVCNT1[31:0] channel 1 event counter, read/write (write loads)
//   0x10 RAW[1:0]     live {i_cnt1_done, i_cnt0_done}, read-only
//   anything else     unmapped: SLVERR, read data 0, no state change
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   i_axi_aw*/w*/b*       AXI4-Lite write address, data and response channels
//   i_axi_ar*/r*          AXI4-Lite read address and data channels
//   i_cnt0_done           done level from timer/counter 0
//   i_cnt1_done           done level from timer/counter 1
//   o_irq                 registered combined interrupt, |(PEND & EN)
// -----------------------------------------------------------------------------
module axi_timer_irq_ctrl #(
  parameter int AXI_ADDR_BW_p = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
  input  logic                     i_axi_awvalid,
  input  logic [31:0]              i_axi_wdata,
  input  logic                     i_axi_wvalid,
  input  logic                     i_axi_bready,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
  input  logic                     i_axi_arvalid,
  input  logic                     i_axi_rready,
  output logic                     o_axi_awready,
  output logic                     o_axi_wready,
  output logic [1:0]               o_axi_bresp,
  output logic                     o_axi_bvalid,
  output logic                     o_axi_arready,
  output logic [31:0]              o_axi_rdata,
  output logic [1:0]               o_axi_rresp,
  output logic                     o_axi_rvalid,
  input  logic                     i_cnt0_done,
  input  logic                     i_cnt1_done,
  output logic                     o_irq
);

  // Word index width after dropping the byte-lane bits.
  localparam int IDX_BW = AXI_ADDR_BW_p - 2;

  localparam logic [IDX_BW-1:0] IDX_PEND   = IDX_BW'(0);
  localparam logic [IDX_BW-1:0] IDX_EN     = IDX_BW'(1);
  localparam logic [IDX_BW-1:0] IDX_EVCNT0 = IDX_BW'(2);
  localparam logic [IDX_BW-1:0] IDX_EVCNT1 = IDX_BW'(3);
  localparam logic [IDX_BW-1:0] IDX_RAW    = IDX_BW'(4);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [1:0]  pend;
  logic [1:0]  en;
  logic [31:0] evcnt0;
  logic [31:0] evcnt1;
  logic        prev0;
  logic        prev1;
  logic        irq_q;

  // AXI response state
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  // ---------------------------------------------------------------------------
  // Handshake and decode signals
  // ---------------------------------------------------------------------------
  logic              edge0;
  logic              edge1;
  logic              wr_fire;
  logic              rd_fire;
  logic [IDX_BW-1:0] wr_idx;
  logic [IDX_BW-1:0] rd_idx;

  logic        wr_pend;
  logic        wr_en;
  logic        wr_ev0;
  logic        wr_ev1;
  logic        wr_mapped;
  logic [31:0] rd_data;
  logic        rd_mapped;
  logic [1:0]  pend_clr;

  // The byte-lane bits of both addresses are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0]};

  assign wr_idx = i_axi_awaddr[AXI_ADDR_BW_p-1:2];
  assign rd_idx = i_axi_araddr[AXI_ADDR_BW_p-1:2];

  // Rising-edge detect. A done level that is already high when reset is
  // released shows up as one edge, because the history resets to zero.
  assign edge0 = i_cnt0_done & ~prev0;
  assign edge1 = i_cnt1_done & ~prev1;

  // A write is taken only when address and data arrive together and no
  // response is still waiting, so exactly one write is ever outstanding.
  // The rst_n gating keeps the ready strobes low while reset is held.
  assign wr_fire = rst_n & i_axi_awvalid & i_axi_wvalid & ~bvalid_q;
  assign rd_fire = rst_n & i_axi_arvalid & ~rvalid_q;

  assign o_axi_awready = wr_fire;
  assign o_axi_wready  = wr_fire;
  assign o_axi_arready = rd_fire;

  assign o_axi_bvalid = bvalid_q;
  assign o_axi_bresp  = bresp_q;
  assign o_axi_rvalid = rvalid_q;
  assign o_axi_rdata  = rdata_q;
  assign o_axi_rresp  = rresp_q;
  assign o_irq        = irq_q;

  // ---------------------------------------------------------------------------
  // Write decode: one strobe per register, asserted only on the accept cycle.
  // RAW is mapped (OKAY) but has no storage, so it has no strobe.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_pend   = 1'b0;
    wr_en     = 1'b0;
    wr_ev0    = 1'b0;
    wr_ev1    = 1'b0;
    wr_mapped = 1'b0;
    case (wr_idx)
      IDX_PEND: begin
        wr_pend   = wr_fire;
        wr_mapped = 1'b1;
      end
      IDX_EN: begin
        wr_en     = wr_fire;
        wr_mapped = 1'b1;
      end
      IDX_EVCNT0: begin
        wr_ev0    = wr_fire;
        wr_mapped = 1'b1;
      end
      IDX_EVCNT1: begin
        wr_ev1    = wr_fire;
        wr_mapped = 1'b1;
      end
      IDX_RAW: begin
        wr_mapped = 1'b1;
      end
      default: begin
        wr_mapped = 1'b0;
      end
    endcase
  end

  // Bits to clear in PEND this cycle (write-1-to-clear).
  assign pend_clr = wr_pend ? i_axi_wdata[1:0] : 2'b00;

  // ---------------------------------------------------------------------------
  // Read mux: unused bits read as zero, unmapped offsets read as zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data   = 32'h0;
    rd_mapped = 1'b1;
    case (rd_idx)
      IDX_PEND:   rd_data = {30'h0, pend};
      IDX_EN:     rd_data = {30'h0, en};
      IDX_EVCNT0: rd_data = evcnt0;
      IDX_EVCNT1: rd_data = evcnt1;
      IDX_RAW:    rd_data = {30'h0, i_cnt1_done, i_cnt0_done};
      default: begin
        rd_data   = 32'h0;
        rd_mapped = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Edge-detect history, sampled every cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev0 <= 1'b0;
      prev1 <= 1'b0;
    end else begin
      prev0 <= i_cnt0_done;
      prev1 <= i_cnt1_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending bits. The clear is applied first and the new edge ORed in after,
  // so an edge arriving in the same cycle as a clear leaves the bit set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= 2'b00;
    end else begin
      pend <= (pend & ~pend_clr) | {edge1, edge0};
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt enables.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en <= 2'b00;
    end else if (wr_en) begin
      en <= i_axi_wdata[1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Event counters. A software load takes priority over a same-cycle edge;
  // that edge's increment is lost. Counters wrap naturally at 32 bits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evcnt0 <= 32'h0;
      evcnt1 <= 32'h0;
    end else begin
      if (wr_ev0) begin
        evcnt0 <= i_axi_wdata;
      end else if (edge0) begin
        evcnt0 <= evcnt0 + 32'd1;
      end
      if (wr_ev1) begin
        evcnt1 <= i_axi_wdata;
      end else if (edge1) begin
        evcnt1 <= evcnt1 + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combined interrupt, registered from the already-registered PEND and EN,
  // so an edge at cycle N raises o_irq at N+2.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(pend & en);
    end
  end

  // ---------------------------------------------------------------------------
  // Write response. bvalid rises the cycle after accept and is held until the
  // master takes it; a new write cannot be accepted while it is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (wr_fire) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && i_axi_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read response. Data is captured on accept and held stable while rvalid
  // waits for rready, even if the underlying register changes meanwhile.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      rresp_q  <= RESP_OKAY;
    end else if (rd_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && i_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_timer_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_timer_irq_ctrl
//
// Directed bench for axi_timer_irq_ctrl. Each AXI transaction pushes its
// expected response into a queue; a monitor running on the falling edge pops
// and compares whenever a read or write response handshake is presented.
// Interrupt-line and stall behaviour are compared directly by the main
// sequence.
// -----------------------------------------------------------------------------
module tb_axi_timer_irq_ctrl;

  localparam int AW = 12;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] i_axi_awaddr;
  logic          i_axi_awvalid;
  logic [31:0]   i_axi_wdata;
  logic          i_axi_wvalid;
  logic          i_axi_bready;
  logic [AW-1:0] i_axi_araddr;
  logic          i_axi_arvalid;
  logic          i_axi_rready;
  logic          o_axi_awready;
  logic          o_axi_wready;
  logic [1:0]    o_axi_bresp;
  logic          o_axi_bvalid;
  logic          o_axi_arready;
  logic [31:0]   o_axi_rdata;
  logic [1:0]    o_axi_rresp;
  logic          o_axi_rvalid;
  logic          i_cnt0_done;
  logic          i_cnt1_done;
  logic          o_irq;

  int assertions = 0;
  int failures   = 0;

  // Scoreboard queues
  logic [31:0]   rd_data_q[$];
  logic [1:0]    rd_resp_q[$];
  logic [AW-1:0] rd_addr_q[$];
  logic [1:0]    wr_resp_q[$];
  logic [AW-1:0] wr_addr_q[$];

  axi_timer_irq_ctrl #(.AXI_ADDR_BW_p(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_axi_awaddr  (i_axi_awaddr),
    .i_axi_awvalid (i_axi_awvalid),
    .i_axi_wdata   (i_axi_wdata),
    .i_axi_wvalid  (i_axi_wvalid),
    .i_axi_bready  (i_axi_bready),
    .i_axi_araddr  (i_axi_araddr),
    .i_axi_arvalid (i_axi_arvalid),
    .i_axi_rready  (i_axi_rready),
    .o_axi_awready (o_axi_awready),
    .o_axi_wready  (o_axi_wready),
    .o_axi_bresp   (o_axi_bresp),
    .o_axi_bvalid  (o_axi_bvalid),
    .o_axi_arready (o_axi_arready),
    .o_axi_rdata   (o_axi_rdata),
    .o_axi_rresp   (o_axi_rresp),
    .o_axi_rvalid  (o_axi_rvalid),
    .i_cnt0_done   (i_cnt0_done),
    .i_cnt1_done   (i_cnt1_done),
    .o_irq         (o_irq)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a handshake never completes at all.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    assertions++;
    failures++;
    $display("[TB] FAIL %s: handshake timeout, got no response, expected one", name);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each response as the DUT presents it with ready high.
  always @(negedge clk) begin
    if (rst_n && o_axi_rvalid && i_axi_rready) begin
      if (rd_data_q.size() == 0) begin
        checkOutput("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        logic [31:0]   d;
        logic [1:0]    r;
        logic [AW-1:0] a;
        d = rd_data_q.pop_front();
        r = rd_resp_q.pop_front();
        a = rd_addr_q.pop_front();
        checkOutput($sformatf("rdata@0x%03h", a), o_axi_rdata, d);
        checkOutput($sformatf("rresp@0x%03h", a), {30'h0, o_axi_rresp}, {30'h0, r});
      end
    end
    if (rst_n && o_axi_bvalid && i_axi_bready) begin
      if (wr_resp_q.size() == 0) begin
        checkOutput("unexpected_bvalid", 32'd1, 32'd0);
      end else begin
        logic [1:0]    r;
        logic [AW-1:0] a;
        r = wr_resp_q.pop_front();
        a = wr_addr_q.pop_front();
        checkOutput($sformatf("bresp@0x%03h", a), {30'h0, o_axi_bresp}, {30'h0, r});
      end
    end
  end

  // One AXI transaction. For reads, data is the expected read data; for
  // writes, it is the data written. exp_resp is the expected response code.
  // Returns just after the rising edge on which the response handshake ends.
  task automatic applyStimulus(input bit is_write, input logic [AW-1:0] addr,
                               input logic [31:0] data, input logic [1:0] exp_resp);
    bit got;
    if (is_write) begin
      wr_resp_q.push_back(exp_resp);
      wr_addr_q.push_back(addr);
      i_axi_awaddr  = addr;
      i_axi_wdata   = data;
      i_axi_awvalid = 1'b1;
      i_axi_wvalid  = 1'b1;
      i_axi_bready  = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (o_axi_awready && o_axi_wready) begin
          got = 1'b1;
          break;
        end
      end
      @(posedge clk);
      #1;
      i_axi_awvalid = 1'b0;
      i_axi_wvalid  = 1'b0;
      if (!got) begin
        reportTimeout($sformatf("aw_accept@0x%03h", addr));
        void'(wr_resp_q.pop_back());
        void'(wr_addr_q.pop_back());
        i_axi_bready = 1'b0;
        return;
      end
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (o_axi_bvalid) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) reportTimeout($sformatf("bvalid@0x%03h", addr));
      @(posedge clk);
      #1;
      i_axi_bready = 1'b0;
    end else begin
      rd_data_q.push_back(data);
      rd_resp_q.push_back(exp_resp);
      rd_addr_q.push_back(addr);
      i_axi_araddr  = addr;
      i_axi_arvalid = 1'b1;
      i_axi_rready  = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (o_axi_arready) begin
          got = 1'b1;
          break;
        end
      end
      @(posedge clk);
      #1;
      i_axi_arvalid = 1'b0;
      if (!got) begin
        reportTimeout($sformatf("ar_accept@0x%03h", addr));
        void'(rd_data_q.pop_back());
        void'(rd_resp_q.pop_back());
        void'(rd_addr_q.pop_back());
        i_axi_rready = 1'b0;
        return;
      end
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (o_axi_rvalid) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) reportTimeout($sformatf("rvalid@0x%03h", addr));
      @(posedge clk);
      #1;
      i_axi_rready = 1'b0;
    end
  endtask

  task automatic flushScoreboard();
    rd_data_q.delete();
    rd_resp_q.delete();
    rd_addr_q.delete();
    wr_resp_q.delete();
    wr_addr_q.delete();
  endtask

  // Main directed sequence
  initial begin
    logic [AW-1:0] reg_addrs[5];
    reg_addrs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010};

    rst_n         = 1'b0;
    i_axi_awaddr  = '0;
    i_axi_awvalid = 1'b0;
    i_axi_wdata   = '0;
    i_axi_wvalid  = 1'b0;
    i_axi_bready  = 1'b0;
    i_axi_araddr  = '0;
    i_axi_arvalid = 1'b0;
    i_axi_rready  = 1'b0;
    i_cnt0_done   = 1'b0;
    i_cnt1_done   = 1'b0;

    repeat (3) tick();
    checkOutput("reset_irq", {31'h0, o_irq}, 32'd0);
    checkOutput("reset_bvalid", {31'h0, o_axi_bvalid}, 32'd0);
    checkOutput("reset_rvalid", {31'h0, o_axi_rvalid}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Every register reads zero after reset.
    foreach (reg_addrs[i]) applyStimulus(1'b0, reg_addrs[i], 32'h0, OKAY);
    checkOutput("irq_after_reset", {31'h0, o_irq}, 32'd0);

    // Single pulse on channel 0 with both enables set: irq at N+2.
    applyStimulus(1'b1, 12'h004, 32'h3, OKAY);
    i_cnt0_done = 1'b1;
    tick();
    checkOutput("irq_at_n1", {31'h0, o_irq}, 32'd0);
    i_cnt0_done = 1'b0;
    tick();
    checkOutput("irq_at_n2", {31'h0, o_irq}, 32'd1);
    applyStimulus(1'b0, 12'h000, 32'h1, OKAY);
    applyStimulus(1'b0, 12'h008, 32'h1, OKAY);
    applyStimulus(1'b1, 12'h000, 32'h1, OKAY);
    checkOutput("irq_after_w1c", {31'h0, o_irq}, 32'd0);
    applyStimulus(1'b0, 12'h000, 32'h0, OKAY);

    // Level held on channel 1 with enables off: one edge, no irq.
    applyStimulus(1'b1, 12'h004, 32'h0, OKAY);
    i_cnt1_done = 1'b1;
    repeat (10) tick();
    checkOutput("irq_masked", {31'h0, o_irq}, 32'd0);
    i_cnt1_done = 1'b0;
    applyStimulus(1'b0, 12'h000, 32'h2, OKAY);
    applyStimulus(1'b0, 12'h00C, 32'h1, OKAY);
    applyStimulus(1'b1, 12'h004, 32'h2, OKAY);
    checkOutput("irq_after_enable", {31'h0, o_irq}, 32'd1);

    // Edge on channel 0 in the same cycle as a W1C of PEND[0]: set wins.
    i_cnt0_done = 1'b1;
    applyStimulus(1'b1, 12'h000, 32'h1, OKAY);
    i_cnt0_done = 1'b0;
    applyStimulus(1'b0, 12'h000, 32'h3, OKAY);
    applyStimulus(1'b0, 12'h008, 32'h2, OKAY);

    // Counter wrap.
    applyStimulus(1'b1, 12'h008, 32'hFFFF_FFFF, OKAY);
    applyStimulus(1'b0, 12'h008, 32'hFFFF_FFFF, OKAY);
    i_cnt0_done = 1'b1;
    tick();
    i_cnt0_done = 1'b0;
    tick();
    applyStimulus(1'b0, 12'h008, 32'h0, OKAY);

    // Load of EVCNT1 in the same cycle as a channel 1 edge: load wins.
    i_cnt1_done = 1'b1;
    applyStimulus(1'b1, 12'h00C, 32'h5, OKAY);
    i_cnt1_done = 1'b0;
    applyStimulus(1'b0, 12'h00C, 32'h5, OKAY);

    // Unmapped offset: SLVERR both ways, nothing changes.
    applyStimulus(1'b1, 12'h020, 32'hFFFF_FFFF, SLVERR);
    applyStimulus(1'b0, 12'h020, 32'h0, SLVERR);
    applyStimulus(1'b0, 12'h004, 32'h2, OKAY);
    applyStimulus(1'b0, 12'h000, 32'h3, OKAY);
    applyStimulus(1'b0, 12'h00C, 32'h5, OKAY);

    // RAW view, RAW write ignored, byte-lane bits ignored in decode.
    i_cnt0_done = 1'b1;
    tick();
    applyStimulus(1'b0, 12'h010, 32'h1, OKAY);
    applyStimulus(1'b1, 12'h010, 32'h3, OKAY);
    i_cnt0_done = 1'b0;
    applyStimulus(1'b0, 12'h008, 32'h1, OKAY);
    applyStimulus(1'b0, 12'h00B, 32'h1, OKAY);
    applyStimulus(1'b0, 12'h004, 32'h2, OKAY);

    // Back-pressure: responses held while ready is low, no second accept.
    wr_resp_q.push_back(OKAY);
    wr_addr_q.push_back(12'h004);
    rd_data_q.push_back(32'h5);
    rd_resp_q.push_back(OKAY);
    rd_addr_q.push_back(12'h00C);
    i_axi_awaddr  = 12'h004;
    i_axi_wdata   = 32'h1;
    i_axi_awvalid = 1'b1;
    i_axi_wvalid  = 1'b1;
    i_axi_araddr  = 12'h00C;
    i_axi_arvalid = 1'b1;
    i_axi_bready  = 1'b0;
    i_axi_rready  = 1'b0;
    @(negedge clk);
    checkOutput("stall_first_awready", {31'h0, o_axi_awready}, 32'd1);
    checkOutput("stall_first_arready", {31'h0, o_axi_arready}, 32'd1);
    tick();
    // A second write and read are presented immediately and must wait.
    i_axi_awaddr = 12'h008;
    i_axi_wdata  = 32'h77;
    i_axi_araddr = 12'h008;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_bvalid_%0d", i), {31'h0, o_axi_bvalid}, 32'd1);
      checkOutput($sformatf("stall_rvalid_%0d", i), {31'h0, o_axi_rvalid}, 32'd1);
      checkOutput($sformatf("stall_rdata_%0d", i), o_axi_rdata, 32'h5);
      checkOutput($sformatf("stall_awready_%0d", i), {31'h0, o_axi_awready}, 32'd0);
      checkOutput($sformatf("stall_arready_%0d", i), {31'h0, o_axi_arready}, 32'd0);
    end
    tick();

    // Reset in the middle of the wait drops both responses.
    rst_n         = 1'b0;
    i_axi_awvalid = 1'b0;
    i_axi_wvalid  = 1'b0;
    i_axi_arvalid = 1'b0;
    tick();
    checkOutput("midreset_bvalid", {31'h0, o_axi_bvalid}, 32'd0);
    checkOutput("midreset_rvalid", {31'h0, o_axi_rvalid}, 32'd0);
    checkOutput("midreset_irq", {31'h0, o_irq}, 32'd0);
    flushScoreboard();

    // Done held high through reset release counts as one edge.
    i_cnt1_done = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b0, 12'h000, 32'h2, OKAY);
    applyStimulus(1'b0, 12'h004, 32'h0, OKAY);
    applyStimulus(1'b0, 12'h008, 32'h0, OKAY);
    applyStimulus(1'b0, 12'h00C, 32'h1, OKAY);
    applyStimulus(1'b0, 12'h010, 32'h2, OKAY);
    checkOutput("irq_after_midreset", {31'h0, o_irq}, 32'd0);
    i_cnt1_done = 1'b0;

    repeat (2) tick();
    checkOutput("scoreboard_drained",
                32'(rd_data_q.size() + wr_resp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
